// File: rtl/threshold_sequencer_if.sv
// Stage handshake and image-address bundle between the sequencer (master)
// and the box-filter / threshold stages (slave).
interface threshold_sequencer_if #(
  parameter int unsigned WIDTH_BITS  = 8,
  parameter int unsigned HEIGHT_BITS = 8
);
  logic                   oFilterStart;
  logic                   iFilterDone;
  logic                   oThreshStart;
  logic                   iThreshDone;
  logic [WIDTH_BITS-1:0]  iFilterCol;
  logic [HEIGHT_BITS-1:0] iFilterRow;
  logic [WIDTH_BITS-1:0]  iThreshCol;
  logic [HEIGHT_BITS-1:0] iThreshRow;
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;

  modport master (
    output oFilterStart, oThreshStart, oImageCol, oImageRow,
    input  iFilterDone, iThreshDone, iFilterCol, iFilterRow, iThreshCol, iThreshRow
  );

  modport slave (
    input  oFilterStart, oThreshStart, oImageCol, oImageRow,
    output iFilterDone, iThreshDone, iFilterCol, iFilterRow, iThreshCol, iThreshRow
  );
endinterface

// File: rtl/threshold_sequencer.sv
// Frame sequencer for the adaptive-thresholding pipeline: start/continuous
// control, per-stage watchdog, frame/cycle statistics and ROM address mux.
module threshold_sequencer #(
  parameter int unsigned WIDTH_BITS   = 8,
  parameter int unsigned HEIGHT_BITS  = 8,
  parameter int unsigned C_BITS       = 5,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter int unsigned CYC_BITS     = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  threshold_sequencer_if.master   stage,
  input  logic                    iStart,
  input  logic                    iContinuous,
  input  logic [C_BITS-1:0]       iC,
  input  logic                    iInvert,
  output logic [C_BITS-1:0]       oC,
  output logic                    oInvert,
  output logic [2:0]              oState,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oError,
  output logic [7:0]              oFrameCount,
  output logic [CYC_BITS-1:0]     oLastCycles,
  output logic [9:0]              LEDR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_THRESH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX  = '1;
  localparam logic [CYC_BITS-1:0]     CYC_MAX = '1;

  state_e                  state_q, state_d;
  logic [C_BITS-1:0]       c_q, c_d;
  logic                    invert_q, invert_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [CYC_BITS-1:0]     cyc_q, cyc_d;
  logic [7:0]              frame_q, frame_d;
  logic [CYC_BITS-1:0]     last_q, last_d;
  logic                    filter_start_q, filter_start_d;
  logic                    thresh_start_q, thresh_start_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic [9:0]              ledr_q, ledr_d;

  logic                    start_frame;
  logic [CYC_BITS-1:0]     cyc_inc;
  logic [4:0]              led_state;
  logic [WIDTH_BITS-1:0]   image_col_c;
  logic [HEIGHT_BITS-1:0]  image_row_c;

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    c_d            = c_q;
    invert_d       = invert_q;
    wd_d           = wd_q;
    cyc_d          = cyc_q;
    frame_d        = frame_q;
    last_d         = last_q;
    filter_start_d = 1'b0;
    thresh_start_d = 1'b0;
    done_d         = 1'b0;
    start_frame    = 1'b0;
    led_state      = 5'b00001;
    cyc_inc        = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_BITS'(1);

    case (state_q)
      ST_IDLE: begin
        if (iStart) start_frame = 1'b1;
      end
      ST_FILTER: begin
        if (stage.iFilterDone) begin
          state_d        = ST_THRESH;
          thresh_start_d = 1'b1;
          wd_d           = '0;
          cyc_d          = cyc_inc;
        end else if (wd_q == WD_MAX) begin
          state_d = ST_ERROR;
        end else begin
          wd_d  = wd_q + TIMEOUT_BITS'(1);
          cyc_d = cyc_inc;
        end
      end
      ST_THRESH: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (stage.iThreshDone) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          frame_d = frame_q + 8'd1;
          last_d  = cyc_inc;
          cyc_d   = cyc_inc;
        end else if (wd_q == WD_MAX) begin
          state_d = ST_ERROR;
        end else begin
          wd_d  = wd_q + TIMEOUT_BITS'(1);
          cyc_d = cyc_inc;
        end
      end
      ST_DONE: begin
        if (iContinuous) start_frame = 1'b1;
        else             state_d     = ST_IDLE;
      end
      ST_ERROR: begin
        if (iStart) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Common frame-entry actions from IDLE and from DONE in continuous mode.
    if (start_frame) begin
      state_d        = ST_FILTER;
      filter_start_d = 1'b1;
      c_d            = iC;
      invert_d       = iInvert;
      wd_d           = '0;
      cyc_d          = '0;
    end

    case (state_d)
      ST_IDLE:   led_state = 5'b00001;
      ST_FILTER: led_state = 5'b00010;
      ST_THRESH: led_state = 5'b00100;
      ST_DONE:   led_state = 5'b01000;
      ST_ERROR:  led_state = 5'b10000;
      default:   led_state = 5'b00001;
    endcase

    busy_d  = (state_d == ST_FILTER) || (state_d == ST_THRESH);
    error_d = (state_d == ST_ERROR);
    ledr_d  = {5'(c_d), led_state};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      c_q            <= '0;
      invert_q       <= 1'b0;
      wd_q           <= '0;
      cyc_q          <= '0;
      frame_q        <= '0;
      last_q         <= '0;
      filter_start_q <= 1'b0;
      thresh_start_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      ledr_q         <= 10'b00000_00001;
    end else begin
      state_q        <= state_d;
      c_q            <= c_d;
      invert_q       <= invert_d;
      wd_q           <= wd_d;
      cyc_q          <= cyc_d;
      frame_q        <= frame_d;
      last_q         <= last_d;
      filter_start_q <= filter_start_d;
      thresh_start_q <= thresh_start_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      ledr_q         <= ledr_d;
    end
  end

  // Shared image ROM address: threshold stage owns it only while in THRESH.
  always_comb begin
    image_col_c = stage.iFilterCol;
    image_row_c = stage.iFilterRow;
    if (state_q == ST_THRESH) begin
      image_col_c = stage.iThreshCol;
      image_row_c = stage.iThreshRow;
    end
  end

  assign stage.oImageCol    = image_col_c;
  assign stage.oImageRow    = image_row_c;
  assign stage.oFilterStart = filter_start_q;
  assign stage.oThreshStart = thresh_start_q;

  assign oC          = c_q;
  assign oInvert     = invert_q;
  assign oState      = state_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = error_q;
  assign oFrameCount = frame_q;
  assign oLastCycles = last_q;
  assign LEDR        = ledr_q;

endmodule

// File: doc/threshold_sequencer.md
Name: threshold_sequencer

Overview:
Parametrised top-level sequencer for the adaptive-thresholding pipeline. It replaces the fixed ready/box-filter/threshold/finished controller with the following additions:
- start handshake and continuous (free-running) mode
- per-stage watchdog with error state
- frame and cycle counters
- latched offset C and output-invert mode
It drives stage start pulses, muxes the shared image-ROM address between the box-filter and threshold stages, and drives status LEDs.

Parameters:
WIDTH_BITS, 8, column address width
HEIGHT_BITS, 8, row address width
C_BITS, 5, width of threshold offset C
TIMEOUT_BITS, 20, watchdog width; timeout fires when stage cycle count reaches 2^TIMEOUT_BITS-1
CYC_BITS, 24, width of per-frame cycle counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iStart  in  1  request a frame run; sampled in IDLE and ERROR
iContinuous  in  1  when 1, DONE loops straight into a new frame
iC  in  C_BITS  threshold offset, latched at frame start
iInvert  in  1  output polarity mode, latched at frame start
oFilterStart  out  1  one-cycle pulse starting box filter
iFilterDone  in  1  box filter finished (level or pulse)
oThreshStart  out  1  one-cycle pulse starting threshold stage
iThreshDone  in  1  threshold stage finished
iFilterCol/iFilterRow  in  WIDTH_BITS/HEIGHT_BITS  box-filter image address
iThreshCol/iThreshRow  in  WIDTH_BITS/HEIGHT_BITS  threshold image address
oImageCol/oImageRow  out  WIDTH_BITS/HEIGHT_BITS  muxed image ROM address
oC  out  C_BITS  latched offset
oInvert  out  1  latched invert mode
oState  out  3  current state encoding
oBusy  out  1  1 in FILTER or THRESH
oDone  out  1  one-cycle pulse on frame completion
oError  out  1  1 while in ERROR
oFrameCount  out  8  completed frames, wraps 255->0
oLastCycles  out  CYC_BITS  cycle count of last completed frame
LEDR  out  10  [9:5]=oC, [4:0]=one-hot state

Behaviour:
- States: IDLE=0, FILTER=1, THRESH=2, DONE=3, ERROR=4. All outputs registered except the oImageCol/oImageRow mux.
- Reset (sync, high): state IDLE; oC=0, oInvert=0, oFrameCount=0, oLastCycles=0; all pulses/flags 0; LEDR=10'b00000_00001.
- IDLE: on iStart=1 at edge n:
  - state=FILTER at n+1
  - oFilterStart=1 for exactly cycle n+1
  - oC<=iC and oInvert<=iInvert
  - watchdog and cycle counter cleared to 0
- FILTER: on iFilterDone=1:
  - next state THRESH
  - oThreshStart pulses 1 cycle on entry
  - watchdog cleared
- THRESH: on iThreshDone=1:
  - next state DONE
  - oDone=1 for that DONE cycle
  - oFrameCount+1
  - oLastCycles <= cycle counter (cycles spent in FILTER+THRESH, inclusive of entry cycles)
- DONE lasts exactly 1 cycle:
  - if iContinuous=1, go to FILTER with the same entry actions as from IDLE (re-latch iC/iInvert, pulse oFilterStart)
  - else go to IDLE
- Watchdog increments each cycle in FILTER/THRESH. When it equals 2^TIMEOUT_BITS-1 and the stage done input is 0:
  - go to ERROR
  - oError=1
  - no oDone, frame count unchanged
- Done and timeout in the same cycle: done wins.
- ERROR is sticky. iStart=1 returns to IDLE only; no stage pulse that cycle, so a new start is needed.
- iStart in FILTER/THRESH/DONE is ignored.
- Done inputs are ignored outside their own state; a stale iFilterDone in THRESH has no effect.
- Changes to iC/iInvert mid-frame do not alter oC/oInvert.
- Dropping iContinuous mid-frame: current frame completes, then IDLE.
- Image mux: oImageCol/Row = iThresh* when state==THRESH, else iFilter* (combinational, zero latency).
- Cycle counter saturates at 2^CYC_BITS-1.
- LEDR[4:0] one-hot: IDLE 00001, FILTER 00010, THRESH 00100, DONE 01000, ERROR 10000. LEDR updates in the same cycle as oState.
- oBusy = (state==FILTER || state==THRESH).

Test Plan:
1. Reset, then iC=5'd12, iStart pulse; iFilterDone 10 cycles after oFilterStart, iThreshDone 20 cycles after oThreshStart -> states 1,2,3,0; oC=12; oDone 1 cycle; oFrameCount=1; oLastCycles=32 (±entry cycles per the rule, checked exactly by the model); LEDR=01100_01000 during DONE.
2. iContinuous=1 for 3 frames, iC changed to 3 mid-frame 2 -> no IDLE between frames; oC switches to 3 only at frame 3 start; oFrameCount=3.
3. TIMEOUT_BITS=4, withhold iFilterDone -> ERROR after 15 FILTER cycles; oError=1; LEDR[4:0]=10000; iStart -> IDLE with no oFilterStart; second iStart runs normally.
4. iThreshDone asserted exactly on the timeout cycle -> DONE, not ERROR.
5. Mux check: drive distinct addresses (filter 8'h11/8'h22, thresh 8'hAA/8'hBB) -> oImageCol/Row follow filter in IDLE/FILTER/DONE and thresh only in THRESH; iStart during THRESH is ignored.
6. Assert reset mid-THRESH -> next cycle IDLE, all outputs at reset values; oFrameCount=0; 256 frames wraps oFrameCount to 0.
